pwl_stream_loader: RTL and testbench

- Multi-slot, host-programmable successor to the fixed-buffer PWL test loader.
- Holds NUM_SLOTS waveform tables of up to MAX_WORDS DMA words each.
- On command, streams one slot as a legal AXI-stream packet into pwl_generator, then runs the generator's rdy_to_run/run/halt handshake.
- Optionally auto-cycles through slots, with abort and error reporting.

---
 rtl/pwl_loader_pkg.sv | 24 ++
 rtl/pwl_slot_mem.sv | 75 +++++++
 rtl/pwl_stream_loader.sv | 217 +++++++++++++++++++++
 tb/tb_pwl_stream_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwl_loader_pkg.sv
// rtl/pwl_loader_pkg.sv - shared state type and width helpers for the PWL stream loader
package pwl_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RDY = 2'd2,
        ST_RUNNING  = 2'd3
    } ld_state_e;

    function automatic int slot_width(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

    function automatic int addr_width(input int max_words);
        return (max_words > 1) ? $clog2(max_words) : 1;
    endfunction

    // Length counts 0..MAX_WORDS inclusive, so it needs one more code than an address.
    function automatic int len_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/pwl_slot_mem.sv
// rtl/pwl_slot_mem.sv - per-slot waveform word store and length table with write locking
module pwl_slot_mem
    import pwl_loader_pkg::*;
#(
    parameter int DMA_DATA_WIDTH = 48,
    parameter int MAX_WORDS      = 64,
    parameter int NUM_SLOTS      = 4,
    parameter int SLOT_W         = slot_width(NUM_SLOTS),
    parameter int ADDR_W         = addr_width(MAX_WORDS),
    parameter int LEN_W          = len_width(MAX_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [SLOT_W-1:0]         wr_slot,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DMA_DATA_WIDTH-1:0] wr_data,
    input  logic                      len_we,
    input  logic [SLOT_W-1:0]         len_slot,
    input  logic [LEN_W-1:0]          len_data,
    input  logic                      lock_en,
    input  logic [SLOT_W-1:0]         lock_slot,
    input  logic [SLOT_W-1:0]         rd_slot,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DMA_DATA_WIDTH-1:0] rd_data,
    output logic [LEN_W-1:0]          rd_len,
    output logic                      wr_dropped
);

    logic [DMA_DATA_WIDTH-1:0] mem_q [NUM_SLOTS][MAX_WORDS];
    logic [LEN_W-1:0]          len_q [NUM_SLOTS];
    logic [LEN_W-1:0]          len_d [NUM_SLOTS];
    logic [LEN_W-1:0]          len_sat;
    logic                      word_hit;
    logic                      len_hit;
    logic                      word_we;
    logic                      len_ok;

    // The slot being streamed or run must not change underneath the FSM.
    assign word_hit   = lock_en && wr_en  && (wr_slot  == lock_slot);
    assign len_hit    = lock_en && len_we && (len_slot == lock_slot);
    assign wr_dropped = word_hit || len_hit;
    assign word_we    = wr_en && !word_hit && (int'(wr_addr) < MAX_WORDS);
    assign len_ok     = len_we && !len_hit;

    assign len_sat = (int'(len_data) > MAX_WORDS) ? LEN_W'(MAX_WORDS) : len_data;

    always_comb begin
        len_d = len_q;
        if (len_ok) begin
            len_d[len_slot] = len_sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                len_q[s] <= '0;
            end
        end else begin
            len_q <= len_d;
        end
    end

    // Word storage carries no reset; contents are only meaningful below the slot length.
    always_ff @(posedge clk) begin
        if (word_we) begin
            mem_q[wr_slot][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_slot][rd_addr];
    assign rd_len  = len_q[rd_slot];

endmodule

// File: rtl/pwl_stream_loader.sv
// rtl/pwl_stream_loader.sv - multi-slot PWL table loader streaming packets into pwl_generator
module pwl_stream_loader
    import pwl_loader_pkg::*;
#(
    parameter int DMA_DATA_WIDTH = 48,
    parameter int MAX_WORDS      = 64,
    parameter int NUM_SLOTS      = 4,
    parameter int SLOT_W         = slot_width(NUM_SLOTS),
    parameter int ADDR_W         = addr_width(MAX_WORDS),
    parameter int LEN_W          = len_width(MAX_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [SLOT_W-1:0]         wr_slot,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DMA_DATA_WIDTH-1:0] wr_data,
    input  logic                      len_we,
    input  logic [SLOT_W-1:0]         len_slot,
    input  logic [LEN_W-1:0]          len_data,
    input  logic                      load_req,
    input  logic [SLOT_W-1:0]         load_slot,
    input  logic                      auto_cycle,
    input  logic                      abort,
    output logic [DMA_DATA_WIDTH-1:0] dma_data,
    output logic                      dma_valid,
    output logic                      dma_last,
    input  logic                      dma_ready,
    input  logic                      rdy_to_run,
    output logic                      run,
    input  logic                      halt,
    output logic                      busy,
    output logic [SLOT_W-1:0]         cur_slot,
    output logic                      load_done,
    output logic                      err_empty,
    output logic                      err_wr
);

    ld_state_e                 state_q, state_d;
    logic [SLOT_W-1:0]         cur_slot_q, cur_slot_d;
    logic [ADDR_W-1:0]         idx_q, idx_d;
    logic [DMA_DATA_WIDTH-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;
    logic                      run_q, run_d;
    logic                      load_done_q, load_done_d;
    logic                      err_empty_q, err_empty_d;
    logic                      err_wr_q, err_wr_d;
    logic                      abort_lat_q, abort_lat_d;

    logic [SLOT_W-1:0]         tgt_slot;
    logic [ADDR_W-1:0]         tgt_addr;
    logic [DMA_DATA_WIDTH-1:0] tgt_data;
    logic [LEN_W-1:0]          tgt_len;
    logic                      wr_dropped;
    logic                      busy_w;
    logic                      start_en;

    assign busy_w = (state_q != ST_IDLE);

    // One read port serves every state: the requested slot when idle, the
    // successor slot when auto-cycling, and the next beat while sending.
    always_comb begin
        tgt_slot = cur_slot_q;
        tgt_addr = '0;
        case (state_q)
            ST_IDLE:    tgt_slot = load_slot;
            ST_SEND:    tgt_addr = idx_q + ADDR_W'(1);
            ST_RUNNING: tgt_slot = cur_slot_q + SLOT_W'(1);
            default:    ;
        endcase
    end

    pwl_slot_mem #(
        .DMA_DATA_WIDTH (DMA_DATA_WIDTH),
        .MAX_WORDS      (MAX_WORDS),
        .NUM_SLOTS      (NUM_SLOTS),
        .SLOT_W         (SLOT_W),
        .ADDR_W         (ADDR_W),
        .LEN_W          (LEN_W)
    ) u_slot_mem (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_slot    (wr_slot),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .len_we     (len_we),
        .len_slot   (len_slot),
        .len_data   (len_data),
        .lock_en    (busy_w),
        .lock_slot  (cur_slot_q),
        .rd_slot    (tgt_slot),
        .rd_addr    (tgt_addr),
        .rd_data    (tgt_data),
        .rd_len     (tgt_len),
        .wr_dropped (wr_dropped)
    );

    always_comb begin
        state_d     = state_q;
        cur_slot_d  = cur_slot_q;
        idx_d       = idx_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        run_d       = 1'b0;
        load_done_d = 1'b0;
        err_empty_d = 1'b0;
        err_wr_d    = wr_dropped;
        abort_lat_d = abort_lat_q;
        start_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    if (tgt_len == '0) begin
                        err_empty_d = 1'b1;
                    end else begin
                        start_en = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (abort) begin
                    abort_lat_d = 1'b1;
                end
                // valid is always high in SEND, so ready alone marks a handshake.
                if (dma_ready) begin
                    if (last_q) begin
                        valid_d     = 1'b0;
                        last_d      = 1'b0;
                        load_done_d = 1'b1;
                        abort_lat_d = 1'b0;
                        state_d     = (abort_lat_q || abort) ? ST_IDLE : ST_WAIT_RDY;
                    end else begin
                        idx_d  = idx_q + ADDR_W'(1);
                        data_d = tgt_data;
                        last_d = (LEN_W'(idx_q) + LEN_W'(2)) == tgt_len;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rdy_to_run) begin
                    run_d   = 1'b1;
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (halt) begin
                    if (!auto_cycle) begin
                        state_d = ST_IDLE;
                    end else if (tgt_len == '0) begin
                        err_empty_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        start_en = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_en) begin
            cur_slot_d  = tgt_slot;
            idx_d       = '0;
            data_d      = tgt_data;
            valid_d     = 1'b1;
            last_d      = (tgt_len == LEN_W'(1));
            abort_lat_d = 1'b0;
            state_d     = ST_SEND;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_slot_q  <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            run_q       <= 1'b0;
            load_done_q <= 1'b0;
            err_empty_q <= 1'b0;
            err_wr_q    <= 1'b0;
            abort_lat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_slot_q  <= cur_slot_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            run_q       <= run_d;
            load_done_q <= load_done_d;
            err_empty_q <= err_empty_d;
            err_wr_q    <= err_wr_d;
            abort_lat_q <= abort_lat_d;
        end
    end

    assign dma_data  = data_q;
    assign dma_valid = valid_q;
    assign dma_last  = last_q;
    assign run       = run_q;
    assign busy      = busy_w;
    assign cur_slot  = cur_slot_q;
    assign load_done = load_done_q;
    assign err_empty = err_empty_q;
    assign err_wr    = err_wr_q;

endmodule

// File: tb/tb_pwl_stream_loader.sv
// tb/tb_pwl_stream_loader.sv - scoreboard bench for pwl_stream_loader
module tb_pwl_stream_loader;

    localparam int DW = 48;
    localparam int MW = 64;
    localparam int NS = 4;
    localparam int SW = 2;
    localparam int AW = 6;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [SW-1:0] wr_slot = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          len_we = 1'b0;
    logic [SW-1:0] len_slot = '0;
    logic [LW-1:0] len_data = '0;
    logic          load_req = 1'b0;
    logic [SW-1:0] load_slot = '0;
    logic          auto_cycle = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] dma_data;
    logic          dma_valid;
    logic          dma_last;
    logic          dma_ready = 1'b1;
    logic          rdy_to_run = 1'b0;
    logic          run;
    logic          halt = 1'b0;
    logic          busy;
    logic [SW-1:0] cur_slot;
    logic          load_done;
    logic          err_empty;
    logic          err_wr;

    always #5 clk = ~clk;

    pwl_stream_loader #(.DMA_DATA_WIDTH(DW), .MAX_WORDS(MW), .NUM_SLOTS(NS)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_we(len_we), .len_slot(len_slot), .len_data(len_data),
        .load_req(load_req), .load_slot(load_slot), .auto_cycle(auto_cycle), .abort(abort),
        .dma_data(dma_data), .dma_valid(dma_valid), .dma_last(dma_last), .dma_ready(dma_ready),
        .rdy_to_run(rdy_to_run), .run(run), .halt(halt), .busy(busy), .cur_slot(cur_slot),
        .load_done(load_done), .err_empty(err_empty), .err_wr(err_wr)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] mdl_mem [NS][MW];
    int            mdl_len [NS];
    int            tests = 0;
    int            fails = 0;
    int            run_cnt = 0;
    int            exp_runs = 0;
    int            ready_mode = 0;
    int            rcnt = 0;
    logic          expect_done = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready pattern source: constant high, the 1,0,0,1 stall pattern, or random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       dma_ready = 1'b1;
            1:       dma_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
            default: dma_ready = 1'($urandom_range(0, 1));
        endcase
        rcnt++;
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability and load_done.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall  = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (expect_done || load_done) check("load_done", load_done, expect_done);
            expect_done = 1'b0;
            if (run) run_cnt++;
            if (prev_stall) begin
                check("stall_valid", dma_valid, 1);
                check("stall_data", dma_data, prev_data);
                check("stall_last", dma_last, prev_last);
            end
            if (dma_valid && dma_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h with empty scoreboard", dma_data);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_data", dma_data, b.data);
                    check("beat_last", dma_last, b.last);
                    if (b.last) expect_done = 1'b1;
                end
            end
            prev_stall = dma_valid && !dma_ready;
            prev_data  = dma_data;
            prev_last  = dma_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int s, input int a, input logic [DW-1:0] d, input bit dropped);
        wr_en = 1'b1; wr_slot = SW'(s); wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (!dropped) mdl_mem[s][a] = d;
    endtask

    task automatic write_len(input int s, input int n, input bit dropped);
        len_we = 1'b1; len_slot = SW'(s); len_data = LW'(n);
        tick();
        len_we = 1'b0;
        if (!dropped) mdl_len[s] = (n > MW) ? MW : n;
    endtask

    task automatic fill_random(input int s, input int n);
        for (int i = 0; i < n; i++) write_word(s, i, DW'({$urandom(), $urandom()}), 1'b0);
    endtask

    task automatic push_pkt(input int s);
        for (int i = 0; i < mdl_len[s]; i++)
            exp_q.push_back('{data: mdl_mem[s][i], last: (i == mdl_len[s] - 1)});
    endtask

    task automatic start_load(input int s);
        push_pkt(s);
        load_req = 1'b1; load_slot = SW'(s);
        tick();
        load_req = 1'b0;
        check("first_valid", dma_valid, 1);
        check("cur_slot", cur_slot, s);
        check("busy_send", busy, 1);
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        while ((exp_q.size() != 0 || dma_valid) && cycles < 3000) begin
            tick();
            cycles++;
        end
        if (cycles >= 3000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_run();
        rdy_to_run = 1'b1;
        tick();
        rdy_to_run = 1'b0;
        exp_runs++;
        check("run_pulse", run, 1);
        tick();
        check("run_single", run, 0);
    endtask

    task automatic do_halt(input bit ac);
        auto_cycle = ac; halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    logic [DW-1:0] t1_words [6];
    int cyc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        t1_words[0] = 48'd131169;       t1_words[1] = 48'd412316991508;
        t1_words[2] = 48'd498216271884; t1_words[3] = 48'd528280912097;
        t1_words[4] = 48'd47244509194;  t1_words[5] = 48'd22;
        for (int s = 0; s < NS; s++) mdl_len[s] = 0;

        tick(); tick();
        check("rst_valid", dma_valid, 0);  check("rst_last", dma_last, 0);
        check("rst_data", dma_data, 0);    check("rst_run", run, 0);
        check("rst_busy", busy, 0);        check("rst_cur_slot", cur_slot, 0);
        check("rst_load_done", load_done, 0);
        check("rst_err_empty", err_empty, 0);
        check("rst_err_wr", err_wr, 0);
        rst = 1'b0;
        tick();

        // Fixed table, ready high: six back-to-back beats then one run pulse.
        for (int i = 0; i < 6; i++) write_word(0, i, t1_words[i], 1'b0);
        write_len(0, 6, 1'b0);
        ready_mode = 0;
        start_load(0);
        wait_drain(cyc);
        check("stream_cycles", cyc, 6);
        check("wait_rdy_busy", busy, 1);
        do_run();
        do_halt(1'b0);
        check("idle_after_halt", busy, 0);

        // Same table under the 1,0,0,1 stall pattern.
        ready_mode = 1;
        start_load(0);
        wait_drain(cyc);
        do_run();
        do_halt(1'b0);

        // Auto-cycle through all slots and wrap back to slot 0.
        ready_mode = 2;
        fill_random(0, 2); write_len(0, 2, 1'b0);
        fill_random(1, 3); write_len(1, 3, 1'b0);
        fill_random(2, 1); write_len(2, 1, 1'b0);
        fill_random(3, 4); write_len(3, 4, 1'b0);
        auto_cycle = 1'b1;
        start_load(0);
        for (int p = 0; p < 5; p++) begin
            wait_drain(cyc);
            check("auto_slot", cur_slot, p % NS);
            do_run();
            if (p < 4) begin
                push_pkt((p + 1) % NS);
                do_halt(1'b1);
                check("auto_restart", dma_valid, 1);
            end else begin
                do_halt(1'b0);
                check("auto_stop", busy, 0);
            end
        end

        // Empty slot: direct request and auto-cycle into it.
        write_len(2, 0, 1'b0);
        load_req = 1'b1; load_slot = 2'd2;
        tick();
        load_req = 1'b0;
        check("empty_err", err_empty, 1);
        check("empty_valid", dma_valid, 0);
        check("empty_busy", busy, 0);
        tick();
        check("empty_err_clear", err_empty, 0);
        start_load(1);
        wait_drain(cyc);
        do_run();
        do_halt(1'b1);
        check("auto_empty_err", err_empty, 1);
        check("auto_empty_busy", busy, 0);
        check("auto_empty_valid", dma_valid, 0);
        auto_cycle = 1'b0;

        // Abort during beat 2 of a 5-beat packet.
        ready_mode = 0;
        fill_random(3, 5); write_len(3, 5, 1'b0);
        start_load(3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_drain(cyc);
        check("abort_idle", busy, 0);
        rdy_to_run = 1'b1;
        tick();
        rdy_to_run = 1'b0;
        check("abort_no_run", run, 0);

        // Abort and halt together with auto-cycle on.
        start_load(3);
        wait_drain(cyc);
        do_run();
        auto_cycle = 1'b1; abort = 1'b1; halt = 1'b1;
        tick();
        abort = 1'b0; halt = 1'b0; auto_cycle = 1'b0;
        check("abort_halt_busy", busy, 0);
        check("abort_halt_valid", dma_valid, 0);
        check("abort_halt_err", err_empty, 0);

        // Writes to the active slot are dropped; other slots still update.
        ready_mode = 1;
        fill_random(1, 4); write_len(1, 4, 1'b0);
        start_load(1);
        write_word(1, 2, 48'hdead_beef_cafe, 1'b1);
        check("err_wr_word", err_wr, 1);
        write_len(1, 1, 1'b1);
        check("err_wr_len", err_wr, 1);
        write_word(0, 5, 48'h1234_5678_9abc, 1'b0);
        check("err_wr_other", err_wr, 0);
        wait_drain(cyc);
        do_run();
        do_halt(1'b0);
        start_load(1);
        wait_drain(cyc);
        do_run();
        do_halt(1'b0);

        // Oversized length saturates to a full-depth packet.
        ready_mode = 2;
        fill_random(3, MW);
        write_len(3, 127, 1'b0);
        start_load(3);
        wait_drain(cyc);
        do_run();
        do_halt(1'b0);

        // Asynchronous reset mid-stream clears the stream and every length.
        ready_mode = 0;
        start_load(3);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", dma_valid, 0);
        check("async_rst_busy", busy, 0);
        exp_q.delete();
        for (int s = 0; s < NS; s++) mdl_len[s] = 0;
        tick();
        rst = 1'b0;
        tick();
        for (int s = 0; s < NS; s++) begin
            load_req = 1'b1; load_slot = SW'(s);
            tick();
            load_req = 1'b0;
            check("post_rst_len0", err_empty, 1);
            check("post_rst_valid", dma_valid, 0);
        end
        tick(); tick();

        check("run_count", run_cnt, exp_runs);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
